uart_tx: RTL and testbench

- UART transmitter. It is the transmit-side counterpart of the existing UART receive path and connects to the uart top's cts_n/tx/tx_data/start_tx/tx_done pins.
- Serialises one 5–8 bit character per request: start bit, data LSB first, optional parity, then 1 or 2 stop bits.
- Frame format is runtime-configurable with the same encoding as the receiver, so a tx→rx loopback is self-consistent.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx.sv | 177 +++++++++++++++++
 tb/tb_uart_tx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: tx FSM state encoding, frame-format constants
// and the data-bit-count helper used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_CTS = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_STOP     = 3'd5
  } tx_state_t;

  localparam logic [1:0] DBITS_5 = 2'b00;
  localparam logic [1:0] DBITS_6 = 2'b01;
  localparam logic [1:0] DBITS_7 = 2'b10;
  localparam logic [1:0] DBITS_8 = 2'b11;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Number of data bits (5..8) selected by a data_bit_num code.
  function automatic logic [3:0] data_bit_count(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and raises bit_tick for one
// cycle on the last count of every bit. clr holds the count at zero.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = !clr && (cnt == LAST);

  // Free-running bit counter, wrapping at each bit boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Optional flow control under macro UART_TX_CTS_EN
// (synchronised cts_n gates the start of each frame via WAIT_CTS).
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | line high, waiting for start_tx
// WAIT_CTS | request captured, waiting for synchronised cts_n=0
// START    | driving the start bit (0)
// DATA     | driving data bit bit_cnt
// PARITY   | driving the parity bit
// STOP     | driving stop bit(s) (1)
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       start_tx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       cts_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

`ifdef UART_TX_CTS_EN
  localparam tx_state_t REQ_STATE = ST_WAIT_CTS;
`else
  localparam tx_state_t REQ_STATE = ST_START;
`endif

  tx_state_t  state, next_state;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] sh_data;
  logic [1:0] sh_dbits;
  logic       sh_stop, sh_pen, sh_ptype;
  logic       tx_next, busy_next, done_next;
  logic       bit_tick, baud_clr, cts_ok;
  logic [2:0] last_idx;
  logic [7:0] data_mask;
  logic       parity_bit;

`ifdef UART_TX_CTS_EN
  logic cts_meta, cts_sync;

  // Two-flop synchroniser for the asynchronous clear-to-send input
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign cts_ok = !cts_sync;
`else
  logic unused_cts;
  assign unused_cts = cts_n;
  assign cts_ok     = 1'b1;
`endif

  assign last_idx   = 3'(data_bit_count(sh_dbits) - 4'd1);
  assign data_mask  = 8'hFF >> (2'd3 - sh_dbits);
  assign parity_bit = (^(sh_data & data_mask)) ^ (sh_ptype == PARITY_ODD);
  assign baud_clr   = (state == ST_IDLE) || (state == ST_WAIT_CTS);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (baud_clr),
    .bit_tick (bit_tick)
  );

  // Capture the character and frame format on an accepted request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_data  <= '0;
      sh_dbits <= DBITS_5;
      sh_stop  <= 1'b0;
      sh_pen   <= 1'b0;
      sh_ptype <= PARITY_EVEN;
    end else if (state == ST_IDLE && start_tx) begin
      sh_data  <= tx_data;
      sh_dbits <= data_bit_num;
      sh_stop  <= stop_bit_num;
      sh_pen   <= parity_en;
      sh_ptype <= parity_type;
    end
  end

  // State, bit index and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= next_state;
      bit_cnt <= bit_cnt_next;
      tx      <= tx_next;
      tx_busy <= busy_next;
      tx_done <= done_next;
    end
  end

  // Next-state and bit-index sequencing on bit boundaries
  always_comb begin
    next_state   = state;
    bit_cnt_next = bit_cnt;
    case (state)
      ST_IDLE: begin
        bit_cnt_next = '0;
        if (start_tx) next_state = REQ_STATE;
      end
      ST_WAIT_CTS: begin
        bit_cnt_next = '0;
        if (cts_ok) next_state = ST_START;
      end
      ST_START: begin
        bit_cnt_next = '0;
        if (bit_tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt == last_idx) begin
            bit_cnt_next = '0;
            next_state   = sh_pen ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) next_state = ST_STOP;
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (bit_cnt == {2'b00, sh_stop}) begin
            bit_cnt_next = '0;
            next_state   = ST_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      default: begin
        next_state   = ST_IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  // Output values for the state being entered, registered on the same edge
  always_comb begin
    busy_next = (next_state != ST_IDLE);
    done_next = (state == ST_STOP) && (next_state == ST_IDLE);
    case (next_state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = sh_data[bit_cnt_next];
      ST_PARITY: tx_next = parity_bit;
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: requests are pushed into a scoreboard queue; a
// line monitor decodes tx bit by bit and compares against frames built
// from the character/format rules.
module tb_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_CTS_EN
  localparam int EXP_LAT = 2;   // request edge -> START entry
`else
  localparam int EXP_LAT = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic [1:0] dbn;
    logic       sbn;
    logic       pe;
    logic       pt;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       start_tx = 1'b0;
  logic [1:0] data_bit_num = '0;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       cts_n = 1'b0;
  logic       tx, tx_busy, tx_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  frame_t exp_q[$];
  int done_q[$];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_data      (tx_data),
    .start_tx     (start_tx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .cts_n        (cts_n),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference frame: start, data LSB first, parity over data, stop bit(s)
  task automatic model_frame(input frame_t f, output logic [11:0] bits, output int n);
    int nd, ones;
    nd   = 5 + int'(f.dbn);
    ones = 0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < nd; i++) begin
      bits[1 + i] = f.data[i];
      ones += int'(f.data[i]);
    end
    n = 1 + nd;
    if (f.pe) begin
      bits[n] = f.pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      n++;
    end
    n += 1 + int'(f.sbn);
  endtask

  // Decode one frame starting at the first low sample of the start bit
  task automatic receive_frame();
    frame_t f;
    logic [11:0] bits;
    int n;
    logic v, stable;
    if (exp_q.size() == 0) begin
      check("unexpected_frame", 32'd1, 32'd0);
      return;
    end
    f = exp_q.pop_front();
    model_frame(f, bits, n);
    for (int b = 0; b < n; b++) begin
      stable = 1'b1;
      v = 1'b0;
      for (int c = 0; c < CPB; c++) begin
        if (b > 0 || c > 0) @(negedge clk);
        if (!reset_n) return;
        if (c == 0) v = tx;
        else if (tx !== v) stable = 1'b0;
      end
      check($sformatf("bit_stable[%0d]", b), {31'd0, stable}, 32'd1);
      if (b > 0) check($sformatf("bit_value[%0d] data=%0h", b, f.data), {31'd0, v}, {31'd0, bits[b]});
    end
    @(negedge clk);
    if (!reset_n) return;
    check("done_at_frame_end", {30'd0, tx_done, tx_busy}, 32'b10);
    done_q.push_back(cyc);
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b1;
      end else begin
        if (prev && !tx) receive_frame();
        prev = tx;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue a request once idle; scramble the format inputs afterwards
  task automatic send(input logic [7:0] d, input logic [1:0] dbn, input logic sbn,
                      input logic pe, input logic pt);
    frame_t f;
    wait_idle();
    tx_data = d; data_bit_num = dbn; stop_bit_num = sbn;
    parity_en = pe; parity_type = pt; start_tx = 1'b1;
    f.data = d & (8'hFF >> (3 - int'(dbn)));
    f.dbn = dbn; f.sbn = sbn; f.pe = pe; f.pt = pt;
    exp_q.push_back(f);
    @(posedge clk); #1;
    start_tx = 1'b0;
    check("busy_after_req", {31'd0, tx_busy}, 32'd1);
    tx_data = 8'($urandom); data_bit_num = 2'($urandom);
    stop_bit_num = 1'($urandom); parity_en = 1'($urandom); parity_type = 1'($urandom);
  endtask

  task automatic pulse_ignored(input logic [7:0] d);
    tx_data = d; data_bit_num = 2'($urandom); start_tx = 1'b1;
    @(posedge clk); #1;
    start_tx = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, ok;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {29'd0, tx, tx_busy, tx_done}, 32'b100);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", {29'd0, tx, tx_busy, tx_done}, 32'b100);

    // 8N1 0xA5 with request-to-start latency
    send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (tx && n < 10) begin @(posedge clk); #1; n++; end
    check("start_latency", n, EXP_LAT - 1);
    send(8'h3C, 2'b10, 1'b1, 1'b1, 1'b1);   // 7O2
    send(8'hF3, 2'b00, 1'b0, 1'b1, 1'b0);   // 5E1, upper bits ignored
    wait_idle();

    // cts_n held high, then released; extra request while busy is dropped
    cts_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(8'h96, 2'b11, 1'b0, 1'b1, 1'b0);
`ifdef UART_TX_CTS_EN
    ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || tx_busy !== 1'b1) ok = 0;
    end
    check("cts_hold", ok, 1);
    pulse_ignored(8'h00);
    cts_n = 1'b0;
    n = 0;
    while (tx && n < 10) begin @(posedge clk); #1; n++; end
    check("cts_release_within_3", {31'd0, (n >= 1 && n <= 3)}, 32'd1);
`else
    repeat (30) @(posedge clk);
    #1;
    pulse_ignored(8'h00);
    cts_n = 1'b0;
`endif
    wait_idle();

    // back-to-back: request in the tx_done cycle
    repeat (5) @(posedge clk);
    #1;
    done_q.delete();
    send(8'hFF, 2'b11, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!tx_done && n < 400) begin @(posedge clk); #1; n++; end
    check("b2b_done_seen", {31'd0, tx_done}, 32'd1);
    begin
      frame_t f;
      tx_data = 8'h00; data_bit_num = 2'b11; stop_bit_num = 1'b0;
      parity_en = 1'b0; parity_type = 1'b0; start_tx = 1'b1;
      f.data = 8'h00; f.dbn = 2'b11; f.sbn = 1'b0; f.pe = 1'b0; f.pt = 1'b0;
      exp_q.push_back(f);
      @(posedge clk); #1;
      start_tx = 1'b0;
    end
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("b2b_done_count", done_q.size(), 2);
    if (done_q.size() == 2)
      check("b2b_done_gap", done_q[1] - done_q[0], 10 * CPB + EXP_LAT);

    // reset in the middle of data bit 3, then a clean frame
    send(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat ((EXP_LAT - 1) + 4 * CPB + CPB / 2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_tx_busy", {30'd0, tx, tx_busy}, 32'b10);
    repeat (3) @(posedge clk);
    #2;
    exp_q.delete();
    reset_n = 1'b1;
    send(8'hC3, 2'b11, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // randomised frames with ignored requests mid-frame
    for (int k = 0; k < 16; k++) begin
      send(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(20, 90)) @(posedge clk);
        #1;
        if (tx_busy) pulse_ignored(8'($urandom));
      end
    end
    wait_idle();
    repeat (40) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
